conv5x5_window_ctrl: RTL
========================

Name: conv5x5_window_ctrl

Overview:
Sequencer for the 5x5 convolution datapath: accepts a raster pixel stream for one frame and drives the shift enable of the line buffers and delay lines. Tracks the column/row position and flags when a complete KxK window is present. Delays that flag by the datapath latency so downstream logic gets a result-valid strobe. Signals frame completion once the pipeline has drained.

Parameters:
IMG_W, 32, frame width in pixels (>= K)
IMG_H, 32, frame height in lines (>= K)
K, 5, kernel size
CW, 6, column/row counter width (2**CW >= max(IMG_W, IMG_H))
PIPE_LAT, 6, cycles from window-valid to datapath result (>= 1)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle frame start pulse
i_pix_valid  in  1  upstream pixel valid
o_pix_ready  out  1  controller accepts a pixel this cycle
o_shift_en  out  1  line-buffer/delay-line enable = i_pix_valid & o_pix_ready (combinational)
o_col  out  CW  column of the next pixel to accept
o_row  out  CW  row of the next pixel to accept
o_win_valid  out  1  registered; full KxK window present at the delay-line outputs
o_out_valid  out  1  o_win_valid delayed PIPE_LAT cycles
o_busy  out  1  high in RUN and FLUSH
o_done  out  1  single-cycle end-of-frame pulse

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_col, o_row, o_win_valid, o_out_valid (entire delay chain), o_done and the flush counter are all 0. o_pix_ready=0, o_busy=0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: o_pix_ready=0. i_start=1 -> RUN; col and row cleared.
- RUN: o_pix_ready=1. Accept = i_pix_valid & o_pix_ready.
  - On accept: col increments.
  - At col==IMG_W-1, col wraps to 0 and row increments.
  - Accepting (IMG_H-1, IMG_W-1) -> FLUSH; col and row return to 0.
  - No accept: counters hold. A pixel-valid gap is a stall, not an error.
- o_win_valid, next value = accept & (row >= K-1) & (col >= K-1), evaluated on pre-increment counters. It is high in the cycle after the accepting edge, aligned with the delay-line outputs.
- Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).
- o_out_valid: PIPE_LAT-stage shift register of o_win_valid. It advances every cycle and is not gated by o_shift_en.
- FLUSH: o_pix_ready=0. The counter runs PIPE_LAT+1 cycles, then -> DONE.
- DONE: o_done=1 for exactly one cycle -> IDLE. The last o_out_valid precedes o_done by exactly one cycle.
- i_start in RUN, FLUSH or DONE: ignored.
- i_start while i_pix_valid=1 in IDLE: the pixel is not accepted that cycle (ready is still 0).
- Reset mid-frame: immediate return to IDLE with all outputs cleared; in-flight valid strobes are discarded.
- Counter arithmetic is unsigned CW-bit. Comparisons use zero-extended parameter constants.

Decomposition:
- Shared package conv5x5_pkg:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - K
  - a CW-derivation helper (clog2 of max dimension)
- The valid delay chain reuses the existing generate_d_ff, instantiated with N=1, D=PIPE_LAT.
- The FSM and counters stay in this module; no further sub-module.

Test Plan:
- Bench params IMG_W=8, IMG_H=6, K=5, PIPE_LAT=3.
- Continuous frame: i_start, then i_pix_valid=1 for 48 cycles -> exactly 8 o_win_valid pulses. The first follows the accept at (row4, col4), which is pixel index 36. o_out_valid mirrors it 3 cycles later. o_done arrives 5 cycles after the last accept.
- Stalls: i_pix_valid toggled 1/0 each cycle -> counters hold during gaps. Still 8 windows and 8 o_out_valid pulses. o_shift_en is never high while i_pix_valid=0.
- Row wrap: check o_col 7->0 with o_row incrementing on the same edge. No o_win_valid for col<4 on any row.
- Reset mid-frame: assert i_rst_n=0 at pixel 40 -> all outputs 0 immediately. A following i_start restarts at (0,0) and yields 8 windows.
- Start ignored: pulse i_start during RUN and during FLUSH -> counters are unaffected and exactly one o_done is produced.
- Idle start with valid: i_pix_valid held high from before i_start -> first accept is the cycle after i_start; the frame still completes with 48 accepts.

Source files
------------

// File: rtl/conv5x5_pkg.sv
// Shared types and constants for the 5x5 convolution window sequencer.
package conv5x5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int K = 5;

    // Position counter width needed to address the larger frame dimension.
    function automatic int cw_for(input int w, input int h);
        return $clog2((w > h) ? w : h);
    endfunction

endpackage

// File: rtl/generate_d_ff.sv
// N-bit, D-stage register delay line with asynchronous clear.
// Latency D cycles; free-running, no backpressure.
module generate_d_ff #(
    parameter int N = 1,
    parameter int D = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_stage [D];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < D; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < D; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[D-1];

endmodule

// File: rtl/conv5x5_window_ctrl.sv
// Frame sequencer for the 5x5 convolution datapath: pixel accept, window-valid, result-valid, done.
// Window flag 1 cycle after accept, result PIPE_LAT later; upstream stalls simply freeze the counters.
module conv5x5_window_ctrl
    import conv5x5_pkg::*;
#(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = conv5x5_pkg::K,
    parameter int CW       = 6,
    parameter int PIPE_LAT = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_pix_valid,
    output logic          o_pix_ready,
    output logic          o_shift_en,
    output logic [CW-1:0] o_col,
    output logic [CW-1:0] o_row,
    output logic          o_win_valid,
    output logic          o_out_valid,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [CW-1:0] LP_COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LP_ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] LP_K_M1     = CW'(K - 1);
    localparam int            FW          = $clog2(PIPE_LAT + 1) + 1;
    localparam logic [FW-1:0] LP_FLUSH_LAST = FW'(PIPE_LAT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_row;
    logic [FW-1:0]   r_flush_cnt;
    logic            r_win_valid;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;

    assign w_accept   = i_pix_valid & o_pix_ready;
    assign w_col_last = (r_col == LP_COL_LAST);
    assign w_row_last = (r_row == LP_ROW_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_col_last && w_row_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == LP_FLUSH_LAST) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_RUN:   begin o_pix_ready = 1'b1; o_busy = 1'b1; end
            ST_FLUSH: o_busy = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default:  ;
        endcase
    end

    // The last accept wraps both counters to zero, ready for the next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_flush_cnt <= '0;
        else if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
        else                          r_flush_cnt <= '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_win_valid <= 1'b0;
        else          r_win_valid <= w_accept & (r_row >= LP_K_M1) & (r_col >= LP_K_M1);
    end

    generate_d_ff #(
        .N (1),
        .D (PIPE_LAT)
    ) u_valid_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_win_valid),
        .o_q     (o_out_valid)
    );

    assign o_shift_en  = w_accept;
    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_win_valid = r_win_valid;

endmodule
